// File: rtl/t_toggle_arbiter.sv
// Round-robin arbiter granting one requester at a time to toggle a shared bank of T flip-flops.
// Each grant runs IDLE -> APPLY -> RELEASE, so a transaction takes three cycles.
module t_toggle_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] mask,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [IdW-1:0]           grant_id,
  output logic [WIDTH-1:0]         q
);

  typedef enum logic [1:0] {StIdle, StApply, StRelease} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   grant_q, grant_d;

  logic [WIDTH-1:0] masks [NUM_REQ];
  logic             found;
  logic [IdW-1:0]   win_idx;
  logic [IdW-1:0]   idx;
  int unsigned      idx_full;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      masks[r] = mask[r*WIDTH +: WIDTH];
    end
  end

  // Search upward from the pointer with wrap; the first set request wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    idx      = '0;
    idx_full = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_full = (32'(ptr_q) + i) % NUM_REQ;
      idx      = IdW'(idx_full);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (en && found) begin
          state_d = StApply;
          mask_d  = masks[win_idx];
          grant_d = win_idx;
        end
      end
      StApply: begin
        q_d     = q_q ^ mask_q;
        ptr_d   = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // Clear only wipes the bank; the transaction itself still completes.
    if (clear) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_q     <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == StRelease) begin
      ack[grant_q] = 1'b1;
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;
  assign q        = q_q;

endmodule

// File: tb/tb_t_toggle_arbiter.sv
// Directed bench for t_toggle_arbiter (NUM_REQ=4, WIDTH=8) with hand-computed expectations.
module tb_t_toggle_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clear;
  logic [3:0]  req;
  logic [31:0] mask;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  q;

  int total;
  int bad;

  t_toggle_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (clear),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_q4 [4];
  int         alt_w [4];
  logic [7:0] alt_q [4];

  initial begin
    total = 0;
    bad   = 0;
    en    = 1'b1;
    clear = 1'b0;
    req   = '0;
    mask  = '0;
    rst_n = 1'b1;
    #2;

    // Single transaction from reset
    rst_n = 1'b0;
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    tick();
    rst_n = 1'b1;
    mask[7:0] = 8'h0F;
    req = 4'b0001;
    tick();
    chk("s1_e0_busy", 32'(busy), 32'h1);
    chk("s1_e0_q", 32'(q), 32'h00);
    chk("s1_e0_ack", 32'(ack), 32'h0);
    tick();
    chk("s1_e1_q", 32'(q), 32'h0F);
    chk("s1_e1_ack", 32'(ack), 32'h1);
    chk("s1_e1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("s1_e2_ack", 32'(ack), 32'h0);
    chk("s1_e2_busy", 32'(busy), 32'h0);
    chk("s1_e2_q", 32'(q), 32'h0F);

    // All four at once: served 0,1,2,3
    do_reset();
    mask = 32'h08_04_02_01;
    req  = 4'b1111;
    exp_q4[0] = 8'h01; exp_q4[1] = 8'h03; exp_q4[2] = 8'h07; exp_q4[3] = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("s2_gid%0d", k), 32'(grant_id), 32'(k));
      chk($sformatf("s2_busy%0d", k), 32'(busy), 32'h1);
      tick();
      chk($sformatf("s2_ack%0d", k), 32'(ack), 32'(1 << k));
      chk($sformatf("s2_q%0d", k), 32'(q), 32'(exp_q4[k]));
      req[k] = 1'b0;
      tick();
      chk($sformatf("s2_idle%0d", k), 32'(busy), 32'h0);
    end
    chk("s2_final_q", 32'(q), 32'h0F);

    // Requesters 0 and 2 alternate
    do_reset();
    mask = 32'h00_01_00_80;
    req  = 4'b0101;
    alt_w[0] = 0; alt_w[1] = 2; alt_w[2] = 0; alt_w[3] = 2;
    alt_q[0] = 8'h80; alt_q[1] = 8'h81; alt_q[2] = 8'h01; alt_q[3] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("s3_gid%0d", k), 32'(grant_id), 32'(alt_w[k]));
      tick();
      chk($sformatf("s3_q%0d", k), 32'(q), 32'(alt_q[k]));
      chk($sformatf("s3_ack%0d", k), 32'(ack), 32'(1 << alt_w[k]));
      req[alt_w[k]] = 1'b0;
      tick();
      req[alt_w[k]] = 1'b1;
    end
    req = 4'b0000;
    tick();

    // Bring q to 0x55, then clear on requester 1's APPLY edge
    mask = 32'h00_00_00_55;
    req  = 4'b0001;
    tick();
    tick();
    chk("s4_q55", 32'(q), 32'h55);
    req = 4'b0000;
    tick();
    mask = 32'h00_00_FF_00;
    req  = 4'b0010;
    tick();
    chk("s4_gid", 32'(grant_id), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("s4_q_clr", 32'(q), 32'h00);
    chk("s4_ack", 32'(ack), 32'h2);
    req = 4'b0000;
    tick();
    chk("s4_ack_off", 32'(ack), 32'h0);

    // en low holds off a pending request
    en   = 1'b0;
    mask = 32'h3C_00_00_00;
    req  = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("s5_hold%0d", k), 32'(busy), 32'h0);
    end
    en = 1'b1;
    tick();
    chk("s5_busy", 32'(busy), 32'h1);
    chk("s5_gid", 32'(grant_id), 32'h3);
    tick();
    chk("s5_ack", 32'(ack), 32'h8);
    chk("s5_q", 32'(q), 32'h3C);
    req = 4'b0000;
    tick();

    // Reset during APPLY drops the transaction and the pointer
    mask = 32'h00_00_00_11;
    req  = 4'b0001;
    tick();
    chk("s6_apply_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("s6_rst_q", 32'(q), 32'h00);
    chk("s6_rst_busy", 32'(busy), 32'h0);
    tick();
    chk("s6_rst_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    mask = 32'h40_00_02_00;
    req  = 4'b1010;
    tick();
    chk("s6_gid_a", 32'(grant_id), 32'h1);
    tick();
    chk("s6_ack_a", 32'(ack), 32'h2);
    chk("s6_q_a", 32'(q), 32'h02);
    req[1] = 1'b0;
    tick();
    tick();
    chk("s6_gid_b", 32'(grant_id), 32'h3);
    tick();
    chk("s6_ack_b", 32'(ack), 32'h8);
    chk("s6_q_b", 32'(q), 32'h42);
    req[3] = 1'b0;
    tick();
    chk("s6_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
